// File: rtl/prefix_sequencer.sv
// 8086 prefix stripper: consumes segment/LOCK/REP prefix bytes, emits the first opcode to the decoder.
// Optional macro PREFIX_LIMIT_EN adds a sticky prefix_overflow flag once prefix_count is saturated.
module prefix_sequencer #(
    parameter int MAX_PREFIXES = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       fifo_rd_data,
    input  logic             fifo_valid,
    output logic             fifo_rd_en,
    input  logic             flush,
    input  logic             next_instruction,
    output logic [7:0]       opcode,
    output logic             opcode_valid,
    input  logic             opcode_ready,
    output logic             seg_override,
    output logic [1:0]       seg_override_sr,
    output logic [1:0]       rep,
    output logic             lock,
    output logic [CNT_W-1:0] prefix_count
`ifdef PREFIX_LIMIT_EN
    ,
    output logic             prefix_overflow
`endif
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        EXEC    = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       opcode_reg, opcode_next;
    logic             valid_reg, valid_next;
    logic             seg_reg, seg_next;
    logic [1:0]       sr_reg, sr_next;
    logic [1:0]       rep_reg, rep_next;
    logic             lock_reg, lock_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             is_seg, is_lock, is_rep, is_prefix;
    logic             count_at_max;
    logic [CNT_W-1:0] count_inc;

    // Segment prefixes are 001x x110; the xx field is the segment register number.
    assign is_seg       = (fifo_rd_data & 8'hE7) == 8'h26;
    assign is_lock      = fifo_rd_data == 8'hF0;
    assign is_rep       = (fifo_rd_data & 8'hFE) == 8'hF2;
    assign is_prefix    = is_seg | is_lock | is_rep;
    assign count_at_max = count_reg == CNT_W'(MAX_PREFIXES);
    assign count_inc    = count_at_max ? count_reg : count_reg + 1'b1;

`ifdef PREFIX_LIMIT_EN
    logic ovf_reg, ovf_next;
    assign prefix_overflow = ovf_reg;
`endif

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        valid_next  = valid_reg;
        seg_next    = 1'b0;
        sr_next     = sr_reg;
        rep_next    = rep_reg;
        lock_next   = lock_reg;
        count_next  = count_reg;
`ifdef PREFIX_LIMIT_EN
        ovf_next    = ovf_reg;
`endif
        fifo_rd_en  = 1'b0;

        case (state_reg)
            COLLECT: begin
                fifo_rd_en = fifo_valid & ~flush;
                if (fifo_rd_en) begin
                    if (is_prefix) begin
                        count_next = count_inc;
`ifdef PREFIX_LIMIT_EN
                        ovf_next = ovf_reg | count_at_max;
`endif
                    end
                    if (is_seg) begin
                        seg_next = 1'b1;
                        sr_next  = fifo_rd_data[4:3];
                    end else if (is_lock) begin
                        lock_next = 1'b1;
                    end else if (is_rep) begin
                        rep_next = {1'b1, fifo_rd_data[0]};
                    end else begin
                        opcode_next = fifo_rd_data;
                        valid_next  = 1'b1;
                        state_next  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (opcode_ready) begin
                    valid_next = 1'b0;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (next_instruction) begin
                    rep_next   = 2'b00;
                    lock_next  = 1'b0;
                    count_next = '0;
`ifdef PREFIX_LIMIT_EN
                    ovf_next   = 1'b0;
`endif
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase

        // Flush overrides everything above, including a simultaneous retire.
        if (flush) begin
            state_next = COLLECT;
            valid_next = 1'b0;
            seg_next   = 1'b0;
            rep_next   = 2'b00;
            lock_next  = 1'b0;
            count_next = '0;
`ifdef PREFIX_LIMIT_EN
            ovf_next   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= COLLECT;
            opcode_reg <= 8'h00;
            valid_reg  <= 1'b0;
            seg_reg    <= 1'b0;
            sr_reg     <= 2'b00;
            rep_reg    <= 2'b00;
            lock_reg   <= 1'b0;
            count_reg  <= '0;
`ifdef PREFIX_LIMIT_EN
            ovf_reg    <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            opcode_reg <= opcode_next;
            valid_reg  <= valid_next;
            seg_reg    <= seg_next;
            sr_reg     <= sr_next;
            rep_reg    <= rep_next;
            lock_reg   <= lock_next;
            count_reg  <= count_next;
`ifdef PREFIX_LIMIT_EN
            ovf_reg    <= ovf_next;
`endif
        end
    end

    assign opcode          = opcode_reg;
    assign opcode_valid    = valid_reg;
    assign seg_override    = seg_reg;
    assign seg_override_sr = sr_reg;
    assign rep             = rep_reg;
    assign lock            = lock_reg;
    assign prefix_count    = count_reg;

endmodule

// File: doc/prefix_sequencer.md
Name: prefix_sequencer

Overview:
Front-end controller that takes instruction bytes from the prefetch FIFO and strips 8086 prefixes (segment, LOCK, REP/REPNE) before handing the first non-prefix opcode to the decoder. Each segment prefix is turned into a one-cycle override command for the segment-select logic. REP and LOCK state is held until the instruction retires. A prefix count is kept so interrupted string instructions can rewind IP to the first prefix.

Parameters:
MAX_PREFIXES, 4, largest prefix count tracked; prefix_count saturates at this value.
CNT_W, 3, width of prefix_count; must satisfy 2**CNT_W > MAX_PREFIXES.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
fifo_rd_data  input  8  byte at the head of the prefetch FIFO.
fifo_valid  input  1  fifo_rd_data is valid.
fifo_rd_en  output  1  pop the FIFO this cycle.
flush  input  1  branch/interrupt flush; drop all prefix and opcode state.
next_instruction  input  1  microcode retire strobe for the current instruction.
opcode  output  8  decoded non-prefix opcode.
opcode_valid  output  1  opcode is presented to the decoder.
opcode_ready  input  1  decoder accepts the opcode.
seg_override  output  1  one-cycle pulse per segment prefix.
seg_override_sr  output  2  segment for the pulse: ES=0, CS=1, SS=2, DS=3.
rep  output  2  00 none, 10 REPNE (F2), 11 REP/REPE (F3).
lock  output  1  LOCK (F0) prefix seen for this instruction.
prefix_count  output  CNT_W  prefixes consumed for this instruction.
prefix_overflow  output  1  present only with PREFIX_LIMIT_EN.

Behaviour:
- Reset values: COLLECT state; opcode=0, opcode_valid=0, seg_override=0, seg_override_sr=0, rep=0, lock=0, prefix_count=0, prefix_overflow=0.
- States:
  - COLLECT: fifo_rd_en = fifo_valid & ~flush. Byte consumption:
    - 26/2E/36/3E: next cycle seg_override=1, seg_override_sr=byte[4:3]; prefix_count+1 (saturating).
    - F0: lock<=1; prefix_count+1.
    - F2/F3: rep<={1,byte[0]}; prefix_count+1.
    - Any other byte: opcode<=byte, opcode_valid<=1, go to HOLD.
  - HOLD: fifo_rd_en=0; opcode and opcode_valid stable until opcode_ready=1; on that handshake opcode_valid<=0 and go to EXEC.
  - EXEC: fifo_rd_en=0; rep, lock and prefix_count held. On next_instruction: clear rep, lock, prefix_count and go to COLLECT (first fetch possible the following cycle).
- Latency: prefix byte to seg_override pulse is 1 cycle. Opcode byte to opcode_valid is 1 cycle. Minimum prefix-free throughput is opcode accept + retire + 1 cycle.
- Multiple segment prefixes: each produces its own pulse; the downstream latch keeps the last, so the last one wins.
- Repeated REP prefixes: the last one wins. Duplicate LOCK: lock stays 1; each prefix still counts.
- seg_override is never asserted outside the cycle after a segment prefix is consumed.
- next_instruction outside EXEC is ignored. opcode_ready outside HOLD is ignored.
- flush has priority in any state. Next cycle: COLLECT, with opcode_valid, rep, lock, prefix_count and prefix_overflow cleared and no seg_override pulse. fifo_rd_en=0 in the flush cycle.
- flush together with next_instruction: the flush result applies.
- reset in any state gives the reset values on the next edge; the in-flight opcode is discarded.
- fifo_valid=0 in COLLECT: stall with no state change.

Optional Feature:
PREFIX_LIMIT_EN
- Defined: the prefix_overflow port exists. Consuming a prefix when prefix_count==MAX_PREFIXES sets prefix_overflow=1, sticky until retire/flush/reset. The prefix itself is still applied.
- Undefined: no port; prefix_count saturates silently.

Test Plan:
- Bytes 2E,8B, opcode_ready=1 → seg_override pulse with sr=1 one cycle after 2E; opcode_valid with opcode=8B next; prefix_count=1.
- Bytes 26,3E,F3,A4 → two pulses, sr=0 then sr=3; rep=11 and prefix_count=3 held until next_instruction, then rep=0 and count=0.
- Byte 90 with opcode_ready held 0 for 5 cycles → opcode_valid=1 and opcode=90 stable, fifo_rd_en=0 throughout; accepted on cycle 6.
- F0,F2 then flush in HOLD → next cycle opcode_valid=0, lock=0, rep=0, count=0; the next byte is popped the following cycle.
- Six F3 prefixes then AD, with PREFIX_LIMIT_EN and MAX_PREFIXES=4 → count saturates at 4, prefix_overflow=1 from the fifth prefix, cleared on next_instruction.
- reset asserted in EXEC with lock=1 → all outputs at reset values next cycle; fifo_valid=0 stalls COLLECT with fifo_rd_en=0.
